// File: rtl/serial_popcount.sv
// Bit-serial population counter: shifts a WIDTH-bit operand BPC bits per clock, counting ones or zeros.
// Optional macro SERIAL_POPCOUNT_ABORT_EN adds an abort input that cancels an operation in progress.
module serial_popcount #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned BPC   = 1,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
`ifdef SERIAL_POPCOUNT_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] a,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    y
);

   localparam int unsigned     STEPS = WIDTH / BPC;
   localparam int unsigned     SW    = $clog2(BPC + 1);
   localparam int unsigned     CNTW  = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNTW-1:0] LAST  = CNTW'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] shreg, shreg_d;
   logic             mode_q, mode_d;
   logic [CW-1:0]    acc, acc_d, acc_sum, y_d;
   logic [CNTW-1:0]  cnt, cnt_d;
   logic [BPC-1:0]   slice_match;
   logic [SW-1:0]    slice_sum;
   logic             busy_d, done_d;
   logic             abort_c;

`ifdef SERIAL_POPCOUNT_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   // Matching bits in the current low slice, added onto the running count
   always_comb begin
      slice_match = shreg[BPC-1:0] ^ {BPC{mode_q}};
      slice_sum   = '0;
      for (int unsigned i = 0; i < BPC; i++) begin
         slice_sum = slice_sum + SW'(slice_match[i]);
      end
      acc_sum = acc + CW'(slice_sum);
   end

   // Next-state, datapath and registered-output values
   always_comb begin
      state_d = state;
      shreg_d = shreg;
      mode_d  = mode_q;
      acc_d   = acc;
      cnt_d   = cnt;
      y_d     = y;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d = SHIFT;
               shreg_d = a;
               mode_d  = mode;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (abort_c) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else begin
               acc_d   = acc_sum;
               shreg_d = shreg >> BPC;
               if (cnt == LAST) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  y_d     = acc_sum;
                  done_d  = 1'b1;
               end else begin
                  cnt_d  = cnt + CNTW'(1);
                  busy_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         shreg  <= '0;
         mode_q <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         y      <= '0;
      end else begin
         state  <= state_d;
         shreg  <= shreg_d;
         mode_q <= mode_d;
         acc    <= acc_d;
         cnt    <= cnt_d;
         busy   <= busy_d;
         done   <= done_d;
         y      <= y_d;
      end
   end

endmodule

// File: tb/tb_serial_popcount.sv
// Bench for serial_popcount: three instances (BPC = 1, 4, 8) share stimulus and are compared each cycle
// against a cycle-count/popcount reference model.
module tb_serial_popcount;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 3;
   localparam int unsigned CW = $clog2(W + 1);
`ifdef SERIAL_POPCOUNT_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, mode, abort;
   logic [W-1:0]  a;
   logic          busy [N];
   logic          done [N];
   logic [CW-1:0] y    [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_popcount #(.WIDTH(W), .BPC(1)) u_bpc1 (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
`ifdef SERIAL_POPCOUNT_ABORT_EN
      .abort(abort),
`endif
      .a(a), .busy(busy[0]), .done(done[0]), .y(y[0]));

   serial_popcount #(.WIDTH(W), .BPC(4)) u_bpc4 (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
`ifdef SERIAL_POPCOUNT_ABORT_EN
      .abort(abort),
`endif
      .a(a), .busy(busy[1]), .done(done[1]), .y(y[1]));

   serial_popcount #(.WIDTH(W), .BPC(8)) u_bpc8 (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
`ifdef SERIAL_POPCOUNT_ABORT_EN
      .abort(abort),
`endif
      .a(a), .busy(busy[2]), .done(done[2]), .y(y[2]));

   // Reference: cycles remaining in the shift phase, result computed up front by popcount
   int kcyc   [N] = '{8, 2, 1};
   int rem    [N] = '{default: 0};
   int m_res  [N] = '{default: 0};
   int m_y    [N] = '{default: 0};
   bit m_done [N] = '{default: 1'b0};

   always @(posedge clk) begin
      for (int j = 0; j < N; j++) begin
         m_done[j] = 1'b0;
         if (reset) begin
            rem[j] = 0;
            m_y[j] = 0;
         end else if (rem[j] > 0) begin
            if (ABORT_EN && abort) begin
               rem[j] = 0;
            end else begin
               rem[j] = rem[j] - 1;
               if (rem[j] == 0) begin
                  m_done[j] = 1'b1;
                  m_y[j]    = m_res[j];
               end
            end
         end else if (start) begin
            rem[j]   = kcyc[j];
            m_res[j] = mode ? (W - $countones(a)) : $countones(a);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         for (int j = 0; j < N; j++) begin
            check($sformatf("busy%0d", j), 32'(busy[j]), 32'(rem[j] > 0));
            check($sformatf("done%0d", j), 32'(done[j]), 32'(m_done[j]));
            check($sformatf("y%0d", j), 32'(y[j]), 32'(m_y[j]));
         end
      end
   endtask

   task automatic pulse_start(input logic m, input logic [W-1:0] av, input int wait_cycles);
      start = 1'b1;
      mode  = m;
      a     = av;
      run(1);
      start = 1'b0;
      run(wait_cycles);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      abort = 1'b0;
      a     = '0;
      run(2);
      check("rst_y", 32'(y[0]), 32'd0);
      check("rst_busy", 32'(busy[0]), 32'd0);
      reset = 1'b0;
      run(1);

      pulse_start(1'b0, 8'b1110_0000, 10);
      check("ones_e0", 32'(y[0]), 32'd3);
      pulse_start(1'b1, 8'b1110_0000, 10);
      check("zeros_e0", 32'(y[0]), 32'd5);
      pulse_start(1'b0, 8'hFF, 10);
      check("ones_ff", 32'(y[0]), 32'd8);
      check("ones_ff_bpc8", 32'(y[2]), 32'd8);
      pulse_start(1'b0, 8'h00, 10);
      check("ones_00", 32'(y[0]), 32'd0);
      pulse_start(1'b0, 8'hB2, 10);
      check("b2_bpc4", 32'(y[1]), 32'd4);

      // Start held high; operand changes mid-shift and is only taken at the next acceptance
      start = 1'b1;
      mode  = 1'b0;
      a     = 8'h0F;
      run(3);
      a = 8'hFF;
      run(6);
      check("b2b_first", 32'(y[0]), 32'd4);
      run(15);
      start = 1'b0;
      run(10);
      check("b2b_second", 32'(y[0]), 32'd8);

      // Reset during the 4th shift cycle
      pulse_start(1'b0, 8'hFF, 3);
      reset = 1'b1;
      run(1);
      reset = 1'b0;
      check("mid_rst_busy", 32'(busy[0]), 32'd0);
      check("mid_rst_y", 32'(y[0]), 32'd0);
      run(12);
      check("mid_rst_y_hold", 32'(y[0]), 32'd0);

`ifdef SERIAL_POPCOUNT_ABORT_EN
      pulse_start(1'b0, 8'b1110_0000, 10);
      pulse_start(1'b0, 8'hFF, 1);
      abort = 1'b1;
      run(1);
      abort = 1'b0;
      check("abort_busy", 32'(busy[0]), 32'd0);
      run(10);
      check("abort_y_hold", 32'(y[0]), 32'd3);
      pulse_start(1'b0, 8'h0F, 10);
      check("after_abort", 32'(y[0]), 32'd4);
`endif

      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 2) == 0);
         mode  = 1'($urandom);
         a     = W'($urandom);
         reset = ($urandom_range(0, 60) == 0);
         abort = ABORT_EN && ($urandom_range(0, 15) == 0);
         run(1);
      end
      start = 1'b0;
      reset = 1'b0;
      abort = 1'b0;
      run(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
